// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and constants for the TX block and the future RX block.
// Contents: tx_state_t FSM encoding, default frame geometry, line levels.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, SETTLE, LOAD, START, DATA, STOP} tx_state_t;
    localparam int   UART_WIDTH        = 8;
    localparam int   UART_CLKS_PER_BIT = 16;
    localparam logic MARK              = 1'b1;
    localparam logic SPACE             = 1'b0;
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: baud counter that flags the last clk cycle of every bit period.
// Ports: clk, rst_n (async, active-low), restart (hold count at 0),
//        bit_done (high on the final cycle of each CLKS_PER_BIT-cycle bit).
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic bit_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    logic [CW-1:0] cnt_q, cnt_d;
    assign bit_done = cnt_q == CW'(CLKS_PER_BIT - 1);
    always_comb cnt_d = (restart || bit_done) ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a FIFO read port and serialises each byte as a start/data/stop frame.
// Ports: clk, rst_n (async, active-low); fifo_empty/fifo_data from the FIFO read side;
//        fifo_rd one-cycle read-advance strobe; tx serial line (idle high); busy frame in progress.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int WIDTH        = UART_WIDTH,
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_rd,
    output logic             tx,
    output logic             busy
);
    localparam int BW = $clog2(WIDTH + 1);
    tx_state_t        state_q, state_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             tx_q, tx_d, rd_q, rd_d, busy_q, busy_d;
    logic             restart, bit_done;
    // The baud counter only runs while a frame is on the wire, so every START begins at count 0.
    assign restart = state_q inside {IDLE, SETTLE, LOAD};
    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart  (restart),
        .bit_done (bit_done)
    );
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        rd_d    = 1'b0;
        case (state_q)
            IDLE:   if (!fifo_empty) state_d = SETTLE;
            SETTLE: state_d = LOAD;
            LOAD:
                if (!fifo_empty) begin
                    sh_d    = fifo_data;
                    rd_d    = 1'b1;
                    state_d = START;
                end else state_d = IDLE;
            START:  if (bit_done) state_d = DATA;
            DATA:
                if (bit_done) begin
                    sh_d  = sh_q >> 1;
                    bit_d = (bit_q == BW'(WIDTH - 1)) ? '0 : bit_q + 1'b1;
                    if (bit_q == BW'(WIDTH - 1)) state_d = STOP;
                end
            STOP:
                if (bit_done) begin
                    if (bit_q == BW'(STOP_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = fifo_empty ? IDLE : SETTLE;
                    end else bit_d = bit_q + 1'b1;
                end
            default: state_d = IDLE;
        endcase
        // tx is registered from the current state, so the line trails the FSM by one cycle.
        tx_d   = (state_q == START) ? SPACE : (state_q == DATA) ? sh_q[0] : MARK;
        // Keeping busy up while leaving STOP covers the delayed last stop cycle on tx.
        busy_d = (state_d != IDLE) || (state_q == STOP);
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= MARK;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
            rd_q    <= rd_d;
            busy_q  <= busy_d;
        end
    assign fifo_rd = rd_q;
    assign tx      = tx_q;
    assign busy    = busy_q;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed and table-driven checks of fifo_uart_tx at CLKS_PER_BIT=4.
module tb_fifo_uart_tx;
    typedef struct {
        int   k;
        logic tx;
        logic busy;
        logic rd;
    } vec_t;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       f_empty = 1'b1;
    logic [7:0] f_data = 8'h00;
    logic [7:0] q[$];
    logic       rd1, tx1, busy1;
    logic       e2 = 1'b1;
    logic [7:0] d2 = 8'hFF;
    logic       rd2, tx2, busy2;
    int         checks = 0, failures = 0, ncyc = 0;
    int         rd_cnt = 0, rd_bad = 0, bad_frames = 0;
    logic       mon_en = 1'b1;
    logic [7:0] rx_q[$], sent_q[$];
    int         st_q[$];
    vec_t       vt[18];

    always #5 clk = ~clk;

    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut (
        .clk(clk), .rst_n(rst_n), .fifo_empty(f_empty), .fifo_data(f_data),
        .fifo_rd(rd1), .tx(tx1), .busy(busy1)
    );
    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .fifo_empty(e2), .fifo_data(d2),
        .fifo_rd(rd2), .tx(tx2), .busy(busy2)
    );

    // FIFO model: data output is one register stage behind the read pointer.
    always @(posedge clk) begin
        ncyc <= ncyc + 1;
        f_data <= (q.size() != 0) ? q[0] : 8'h00;
        if (rd1 && q.size() != 0) void'(q.pop_front());
        if (wr_en) q.push_back(wr_data);
        f_empty <= (q.size() == 0);
    end

    always @(negedge clk) begin
        if (rd1) rd_cnt++;
        if (rd1 && f_empty) rd_bad++;
    end

    // Line decoder: samples mid-bit, 4 clocks per bit.
    initial begin
        logic [7:0] b;
        logic       ok;
        int         st;
        forever begin
            @(negedge clk);
            if (tx1 === 1'b0) begin
                st = ncyc;
                ok = 1'b1;
                repeat (2) @(negedge clk);
                ok &= (tx1 === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    b[i] = tx1;
                end
                repeat (4) @(negedge clk);
                ok &= (tx1 === 1'b1);
                if (mon_en) begin
                    rx_q.push_back(b);
                    st_q.push_back(st);
                    if (!ok) bad_frames++;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        wr_en = 1'b1;
        wr_data = b;
        sent_q.push_back(b);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic clr();
        #1;
        rx_q.delete();
        st_q.delete();
        sent_q.delete();
        rd_cnt = 0;
    endtask

    initial begin
        int n, bad, prev, lowc, f, lows;
        // k = negedges after the edge that first sees fifo_empty=0; frame of 0x55 at 4 clk/bit
        vt[0]  = '{0, 1, 1, 0};  vt[1]  = '{1, 1, 1, 0};  vt[2]  = '{2, 1, 1, 1};
        vt[3]  = '{3, 0, 1, 0};  vt[4]  = '{6, 0, 1, 0};  vt[5]  = '{7, 1, 1, 0};
        vt[6]  = '{10, 1, 1, 0}; vt[7]  = '{11, 0, 1, 0}; vt[8]  = '{15, 1, 1, 0};
        vt[9]  = '{19, 0, 1, 0}; vt[10] = '{23, 1, 1, 0}; vt[11] = '{27, 0, 1, 0};
        vt[12] = '{31, 1, 1, 0}; vt[13] = '{35, 0, 1, 0}; vt[14] = '{38, 0, 1, 0};
        vt[15] = '{39, 1, 1, 0}; vt[16] = '{42, 1, 1, 0}; vt[17] = '{43, 1, 0, 0};

        repeat (3) @(negedge clk);
        chk("rst_tx", tx1, 1);
        chk("rst_busy", busy1, 0);
        chk("rst_rd", rd1, 0);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx1 !== 1'b1 || busy1 !== 1'b0 || rd1 !== 1'b0 || tx2 !== 1'b1 || busy2 !== 1'b0) bad++;
        end
        chk("idle100", bad, 0);

        // single frame 0x55, cycle-exact
        clr();
        @(negedge clk);
        push(8'h55);
        for (n = 0; n < 20 && busy1 !== 1'b1; n++) @(negedge clk);
        chk("t2_busy_rise", busy1, 1);
        prev = 0;
        for (int i = 0; i < 18; i++) begin
            repeat (vt[i].k - prev) @(negedge clk);
            prev = vt[i].k;
            chk($sformatf("v%0d_k%0d_tx", i, vt[i].k), tx1, vt[i].tx);
            chk($sformatf("v%0d_k%0d_busy", i, vt[i].k), busy1, vt[i].busy);
            chk($sformatf("v%0d_k%0d_rd", i, vt[i].k), rd1, vt[i].rd);
        end
        repeat (3) @(negedge clk);
        chk("t2_nrx", rx_q.size(), 1);
        if (rx_q.size() == 1) chk("t2_byte", rx_q[0], 8'h55);
        chk("t2_rdcnt", rd_cnt, 1);

        // back-to-back 0xA3, 0x0F
        clr();
        @(negedge clk);
        push(8'hA3);
        push(8'h0F);
        for (n = 0; n < 20 && busy1 !== 1'b1; n++) @(negedge clk);
        lowc = 0;
        for (n = 0; n < 300 && rx_q.size() < 2; n++) begin
            @(negedge clk);
            if (busy1 !== 1'b1) lowc++;
        end
        chk("t3_nrx", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            chk("t3_byte0", rx_q[0], 8'hA3);
            chk("t3_byte1", rx_q[1], 8'h0F);
            chk("t3_start_spacing", st_q[1] - st_q[0], 42);
        end
        chk("t3_busy_low", lowc, 0);
        repeat (10) @(negedge clk);
        chk("t3_rdcnt", rd_cnt, 2);
        chk("t3_busy_end", busy1, 0);

        // two stop bits, 0xFF
        e2 = 1'b0;
        for (n = 0; n < 20 && rd2 !== 1'b1; n++) @(negedge clk);
        chk("t4_rd", rd2, 1);
        e2 = 1'b1;
        for (n = 0; n < 20 && tx2 !== 1'b0; n++) @(negedge clk);
        chk("t4_fall", tx2, 0);
        f = ncyc;
        lows = 0;
        for (n = 0; n < 100 && busy2 !== 1'b0; n++) begin
            if (tx2 === 1'b0) lows++;
            @(negedge clk);
        end
        chk("t4_frame_len", ncyc - f, 44);
        chk("t4_start_len", lows, 4);
        chk("t4_tx_idle", tx2, 1);

        // asynchronous reset in DATA bit 3 of 0x00
        clr();
        mon_en = 1'b0;
        @(negedge clk);
        push(8'h00);
        for (n = 0; n < 30 && tx1 !== 1'b0; n++) @(negedge clk);
        chk("t5_fall", tx1, 0);
        repeat (17) @(negedge clk);
        #1;
        chk("t5_pre_tx", tx1, 0);
        chk("t5_pre_busy", busy1, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_tx", tx1, 1);
        chk("t5_rst_busy", busy1, 0);
        chk("t5_rst_rd", rd1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx1 !== 1'b1 || busy1 !== 1'b0 || rd1 !== 1'b0) bad++;
        end
        chk("t5_idle", bad, 0);
        mon_en = 1'b1;

        // random stream with random write gaps
        clr();
        bad_frames = 0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            push(8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 60)) @(negedge clk);
        end
        for (n = 0; n < 3000 && rx_q.size() < 16; n++) @(negedge clk);
        chk("t6_nrx", rx_q.size(), 16);
        if (rx_q.size() == 16)
            for (int i = 0; i < 16; i++) chk($sformatf("t6_byte%0d", i), rx_q[i], sent_q[i]);
        repeat (10) @(negedge clk);
        chk("t6_rdcnt", rd_cnt, 16);
        chk("t6_framing", bad_frames, 0);
        chk("rd_while_empty", rd_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
